// File: rtl/mux_sel_rr_arbiter.sv
// mux_sel_rr_arbiter: round-robin arbiter driving a 4:1 mux select with valid/ready
// handshake and a grant-hold timeout that releases a stalled winner.
module mux_sel_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [1:0] select,
    output logic [3:0] grant,
    output logic       out_valid,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       base, win_idx;
    logic             win_any, hs;

    assign hs   = valid_q & out_ready;
    // In GRANT the only arbitration that matters happens on a handshake, whose new pointer is sel+1
    assign base = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;

    always_comb begin
        win_any = 1'b0;
        win_idx = base;
        for (int i = 3; i >= 0; i--) begin
            if (req[base + 2'(i)]) begin
                win_any = 1'b1;
                win_idx = base + 2'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        if (state_q == IDLE || hs) begin
            if (state_q == GRANT) ptr_d = base;
            if (win_any) begin
                state_d = GRANT;
                sel_d   = win_idx;
                grant_d = 4'b0001 << win_idx;
                valid_d = 1'b1;
                cnt_d   = '0;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        end else if (!req[sel_q]) begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
        end else if (MAX_HOLD > 0 && cnt_q == CNT_MAX) begin
            state_d   = IDLE;
            grant_d   = '0;
            valid_d   = 1'b0;
            timeout_d = 1'b1;
            ptr_d     = base;
        end else if (MAX_HOLD > 0) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign select    = sel_q;
    assign grant     = grant_q;
    assign out_valid = valid_q;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// tb_mux_sel_rr_arbiter: directed vectors; observed word is {select, grant, out_valid, timeout}.
module tb_mux_sel_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] select;
    logic [3:0] grant;
    logic       out_valid;
    logic       timeout;
    int         n_chk = 0;
    int         n_fail = 0;

    mux_sel_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .select(select), .grant(grant), .out_valid(out_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {select, grant, out_valid, timeout};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'hF; out_ready = 1'b1;
        repeat (3) begin
            tick();
            check("rst_hold", obs(), 8'b00_0000_00);
        end
        rst_n = 1'b1;
        tick(); check("first_grant0", obs(), 8'b00_0001_10);
        tick(); check("rr_1", obs(), 8'b01_0010_10);
        tick(); check("rr_2", obs(), 8'b10_0100_10);
        tick(); check("rr_3", obs(), 8'b11_1000_10);
        tick(); check("rr_wrap0", obs(), 8'b00_0001_10);
        req = 4'b0100;
        tick(); check("req2_grant", obs(), 8'b10_0100_10);
        req = 4'b0000;
        tick(); check("hs_to_idle", obs(), 8'b10_0000_00);
        req = 4'hF;
        tick(); check("ptr3_grant", obs(), 8'b11_1000_10);
        req = 4'b0000;
        tick(); check("idle_again", obs(), 8'b11_0000_00);
        req = 4'b0010; out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("hold1_%0d", k), obs(), 8'b01_0010_10);
        end
        tick(); check("timeout_pulse", obs(), 8'b01_0000_01);
        tick(); check("regrant1", obs(), 8'b01_0010_10);
        req = 4'b1000;
        tick(); check("withdraw1", obs(), 8'b01_0000_00);
        tick(); check("grant3_from_ptr2", obs(), 8'b11_1000_10);
        req = 4'b0000; out_ready = 1'b1;
        tick(); check("hs3_idle", obs(), 8'b11_0000_00);
        req = 4'b1001; out_ready = 1'b0;
        tick(); check("grant0_of_1001", obs(), 8'b00_0001_10);
        tick(); check("hold0", obs(), 8'b00_0001_10);
        req = 4'b1000;
        tick(); check("withdraw0", obs(), 8'b00_0000_00);
        tick(); check("then3", obs(), 8'b11_1000_10);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("hold3_%0d", k), obs(), 8'b11_1000_10);
        end
        req = 4'b0100; out_ready = 1'b1;
        tick(); check("hs_beats_timeout", obs(), 8'b10_0100_10);
        out_ready = 1'b0;
        tick(); check("grant2_hold", obs(), 8'b10_0100_10);
        #2 rst_n = 1'b0;
        #1 check("async_rst", obs(), 8'b00_0000_00);
        tick(); check("rst_held", obs(), 8'b00_0000_00);
        req = 4'hF; rst_n = 1'b1;
        tick(); check("post_rst_grant0", obs(), 8'b00_0001_10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
